bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder_structural.sv | 20 ++
 rtl/bit_serial_adder.sv | 105 ++++++++++
 tb/tb_bit_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/full_adder_structural.sv
// Gate-level 1-bit full adder used for the per-bit step of the serial adder.
module full_adder_structural (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_xor;
    logic ab_and;
    logic c_and;

    xor u_x0 (ab_xor, a, b);
    xor u_x1 (sum, ab_xor, cin);
    and u_a0 (ab_and, a, b);
    and u_a1 (c_and, ab_xor, cin);
    or  u_o0 (cout, ab_and, c_and);

endmodule : full_adder_structural

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first, with valid/ready on both sides.
module bit_serial_adder
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("bit_serial_adder: WIDTH must be in 1..32");
        end
    endgenerate

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   sum_shift;

    full_adder_structural u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; slicing the widened vector keeps WIDTH=1 legal.
    assign sum_shift = {fa_sum, sum_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            start_ready <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        op_a        <= a;
                        op_b        <= b;
                        carry       <= cin;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_cout;
                    sum_r <= sum_shift[WIDTH:1];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid   <= 1'b0;
                    start_ready <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = carry;
    assign busy = (state != ST_IDLE);

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       s8_valid = 1'b0;
    logic       s8_ready;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       r8_valid;
    logic       r8_ready = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;

    logic s1_valid = 1'b0;
    logic s1_ready;
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic cin1 = 1'b0;
    logic r1_valid;
    logic r1_ready = 1'b0;
    logic sum1;
    logic cout1;
    logic busy1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (s8_valid),
        .start_ready (s8_ready),
        .a           (a8),
        .b           (b8),
        .cin         (cin8),
        .res_valid   (r8_valid),
        .res_ready   (r8_ready),
        .sum         (sum8),
        .cout        (cout8),
        .busy        (busy8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (s1_valid),
        .start_ready (s1_ready),
        .a           (a1),
        .b           (b1),
        .cin         (cin1),
        .res_valid   (r1_valid),
        .res_ready   (r1_ready),
        .sum         (sum1),
        .cout        (cout1),
        .busy        (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; disturb keeps start_valid high with changing operands while busy.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input int hold, input bit disturb);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        lat = 0;
        while (!s8_ready && lat < 20) begin
            tick();
            lat++;
        end
        check("start_ready8", 32'(s8_ready), 32'd1);
        a8 = ta; b8 = tb; cin8 = tc; s8_valid = 1'b1; r8_ready = 1'b0;
        tick();
        s8_valid = disturb;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check("busy_run8", 32'(busy8), 32'd1);
        check("ready_run8", 32'(s8_ready), 32'd0);
        lat = 0;
        while (!r8_valid && lat < 40) begin
            tick();
            lat++;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
        check("latency8", 32'(lat), 32'd8);
        check("sum8", 32'(sum8), 32'(exp[7:0]));
        check("cout8", 32'(cout8), 32'(exp[8]));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid8", 32'(r8_valid), 32'd1);
            check("hold_sum8", 32'(sum8), 32'(exp[7:0]));
            check("hold_cout8", 32'(cout8), 32'(exp[8]));
            check("hold_ready8", 32'(s8_ready), 32'd0);
        end
        s8_valid = 1'b0;
        r8_ready = 1'b1;
        tick();
        r8_ready = 1'b0;
        check("idle_valid8", 32'(r8_valid), 32'd0);
        check("idle_ready8", 32'(s8_ready), 32'd1);
        check("idle_busy8", 32'(busy8), 32'd0);
        check("idle_sum8", 32'(sum8), 32'(exp[7:0]));
        check("idle_cout8", 32'(cout8), 32'(exp[8]));
    endtask

    task automatic run1(input logic ta, input logic tb, input logic tc);
        logic [1:0] exp;
        int lat;
        exp = {1'b0, ta} + {1'b0, tb} + {1'b0, tc};
        check("start_ready1", 32'(s1_ready), 32'd1);
        a1 = ta; b1 = tb; cin1 = tc; s1_valid = 1'b1; r1_ready = 1'b0;
        tick();
        s1_valid = 1'b0;
        lat = 0;
        while (!r1_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency1", 32'(lat), 32'd1);
        check("sum1", 32'(sum1), 32'(exp[0]));
        check("cout1", 32'(cout1), 32'(exp[1]));
        r1_ready = 1'b1;
        tick();
        r1_ready = 1'b0;
        check("idle_ready1", 32'(s1_ready), 32'd1);
        check("idle_valid1", 32'(r1_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_valid8", 32'(r8_valid), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_ready8", 32'(s8_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready8", 32'(s8_ready), 32'd1);
        check("post_rst_ready1", 32'(s1_ready), 32'd1);

        run8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run8(8'h00, 8'h00, 1'b1, 0, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
        run8(8'h81, 8'h7F, 1'b0, 5, 1'b0);
        run8(8'h13, 8'h22, 1'b1, 3, 1'b1);

        // Reset in the middle of RUN, then a clean operation.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; s8_valid = 1'b1;
        tick();
        s8_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sum8", 32'(sum8), 32'd0);
        check("abort_cout8", 32'(cout8), 32'd0);
        check("abort_valid8", 32'(r8_valid), 32'd0);
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_ready8", 32'(s8_ready), 32'd0);
        tick();
        check("abort_idle_valid8", 32'(r8_valid), 32'd0);
        run8(8'h3C, 8'h0F, 1'b0, 0, 1'b0);

        for (int i = 0; i < 25; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_bit_serial_adder
